// File: rtl/rgb_pwm_sequencer_if.sv
// Run request in, three-channel PWM drive and sequencer state out.
interface rgb_pwm_sequencer_if;
  logic       seq_enable;
  logic       pwm_red;
  logic       pwm_green;
  logic       pwm_blue;
  logic [2:0] seq_state;

  modport master (
    output seq_enable,
    input  pwm_red, pwm_green, pwm_blue, seq_state
  );

  modport slave (
    input  seq_enable,
    output pwm_red, pwm_green, pwm_blue, seq_state
  );
endinterface

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED sequencer: RED->GREEN->BLUE->WHITE, 256-cycle PWM with period-aligned duty.
// Define RGB_BREATHE_EN for up/down duty breathing; otherwise each colour is held at full duty.
module rgb_pwm_sequencer #(
  parameter int unsigned STEP_CYCLES = 23437,
  parameter int unsigned HOLD_STEPS  = 512
) (
  input logic                clk_12Mhz,
  input logic                rst_n,
  rgb_pwm_sequencer_if.slave seq_if
);
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED   = 3'd1,
    GREEN = 3'd2,
    BLUE  = 3'd3,
    WHITE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              en_meta, en_s;
  logic [7:0]        pwm_cnt;
  logic [7:0]        duty, duty_nxt, duty_shadow;
  logic [STEP_W-1:0] step_cnt;
  logic              step_tick;
  logic              advance;
  logic              pwm_hi;

`ifdef RGB_BREATHE_EN
  localparam logic [7:0] ENTRY_DUTY = 8'd0;
  logic ramp_down, ramp_down_nxt;
`else
  localparam logic [7:0] ENTRY_DUTY = 8'hFF;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
`endif

  always_ff @(posedge clk_12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      en_meta <= seq_if.seq_enable;
      en_s    <= en_meta;
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign step_tick = (state != IDLE) && (step_cnt == STEP_W'(STEP_CYCLES - 1));

  always_ff @(posedge clk_12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (state == IDLE || state_nxt == IDLE || step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    advance   = 1'b0;
`ifdef RGB_BREATHE_EN
    ramp_down_nxt = ramp_down;
`else
    hold_cnt_nxt  = hold_cnt;
`endif
    if (!en_s) begin
      state_nxt = IDLE;
      duty_nxt  = '0;
`ifdef RGB_BREATHE_EN
      ramp_down_nxt = 1'b0;
`else
      hold_cnt_nxt  = '0;
`endif
    end else if (state == IDLE) begin
      state_nxt = RED;
      duty_nxt  = ENTRY_DUTY;
`ifdef RGB_BREATHE_EN
      ramp_down_nxt = 1'b0;
`else
      hold_cnt_nxt  = '0;
`endif
    end else if (step_tick) begin
`ifdef RGB_BREATHE_EN
      // Turnaround at 255 decrements on the same tick, so a colour spans 511 ticks.
      if (!ramp_down) begin
        if (duty == 8'hFF) begin
          ramp_down_nxt = 1'b1;
          duty_nxt      = duty - 8'd1;
        end else begin
          duty_nxt = duty + 8'd1;
        end
      end else if (duty == 8'd0) begin
        advance = 1'b1;
      end else begin
        duty_nxt = duty - 8'd1;
      end
`else
      if (hold_cnt == HOLD_W'(HOLD_STEPS - 1)) advance = 1'b1;
      else                                      hold_cnt_nxt = hold_cnt + HOLD_W'(1);
`endif
      if (advance) begin
        duty_nxt = ENTRY_DUTY;
`ifdef RGB_BREATHE_EN
        ramp_down_nxt = 1'b0;
`else
        hold_cnt_nxt  = '0;
`endif
        case (state)
          RED:     state_nxt = GREEN;
          GREEN:   state_nxt = BLUE;
          BLUE:    state_nxt = WHITE;
          default: state_nxt = RED;
        endcase
      end
    end
  end

  always_ff @(posedge clk_12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      duty  <= '0;
`ifdef RGB_BREATHE_EN
      ramp_down <= 1'b0;
`else
      hold_cnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      duty  <= duty_nxt;
`ifdef RGB_BREATHE_EN
      ramp_down <= ramp_down_nxt;
`else
      hold_cnt  <= hold_cnt_nxt;
`endif
    end
  end

  assign pwm_hi = pwm_cnt < duty_shadow;

  // Channel select uses the next state so a disable blanks outputs without waiting for period end.
  always_ff @(posedge clk_12Mhz or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow      <= '0;
      seq_if.pwm_red   <= 1'b0;
      seq_if.pwm_green <= 1'b0;
      seq_if.pwm_blue  <= 1'b0;
    end else begin
      if (state_nxt == IDLE)      duty_shadow <= '0;
      else if (pwm_cnt == 8'hFF)  duty_shadow <= duty;
      seq_if.pwm_red   <= pwm_hi && (state_nxt == RED   || state_nxt == WHITE);
      seq_if.pwm_green <= pwm_hi && (state_nxt == GREEN || state_nxt == WHITE);
      seq_if.pwm_blue  <= pwm_hi && (state_nxt == BLUE  || state_nxt == WHITE);
    end
  end

  assign seq_if.seq_state = state;
endmodule

// File: doc/rgb_pwm_sequencer.md
RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 23437: clk_12Mhz cycles per duty step tick.
REQ-002 Parameter HOLD_STEPS, default 512: step ticks each colour is held when breathing is compiled out.
REQ-003 Port clk_12Mhz, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port seq_enable, input, 1: asynchronous run request (board switch).
REQ-006 Port pwm_red, output, 1: PWM drive for the RGB driver red channel (RGB0PWM).
REQ-007 Port pwm_green, output, 1: PWM drive for the green channel (RGB1PWM).
REQ-008 Port pwm_blue, output, 1: PWM drive for the blue channel (RGB2PWM).
REQ-009 Port seq_state, output, 3: current sequencer state encoding (IDLE=0, RED=1, GREEN=2, BLUE=3, WHITE=4).

Function
REQ-010 seq_enable SHALL pass through a 2-flop synchronizer; only the synchronized value (en_s) is used.
REQ-011 An 8-bit pwm_cnt SHALL increment every cycle, wrapping 255->0, giving a 256-cycle PWM period.
REQ-012 An 8-bit duty_shadow SHALL load the working duty register only in the cycle pwm_cnt==255; duty changes never take effect mid-period.
REQ-013 Each active-colour pwm output SHALL be registered: high in the cycle after pwm_cnt < duty_shadow; duty 0 gives constantly low; duty 255 gives 255 high cycles per 256.
REQ-014 Inactive colours SHALL be driven 0; WHITE drives all three channels from the same duty_shadow.
REQ-015 A step counter SHALL count 0..STEP_CYCLES-1 and issue a one-cycle step tick on wrap; it runs only outside IDLE and clears on entry to IDLE.
REQ-016 States: IDLE, RED, GREEN, BLUE, WHITE; order RED->GREEN->BLUE->WHITE->RED.
REQ-017 IDLE->RED when en_s==1; duty, step counter and ramp phase cleared on entry to RED.
REQ-018 Any state->IDLE on the cycle after en_s==0 is observed, regardless of ramp position; duty forced to 0 immediately, outputs low from the next cycle (not waiting for PWM period end).
REQ-019 On each colour advance, duty SHALL reset to 0 and the ramp phase to UP.
REQ-020 seq_state SHALL reflect the state register directly (no added latency).
REQ-021 duty arithmetic is 8-bit unsigned with explicit saturation checks; no wrap 255->0 or 0->255 shall occur.

Reset
REQ-022 While rst_n==0: state IDLE, pwm_red/pwm_green/pwm_blue 0, seq_state 0, pwm_cnt, duty, duty_shadow, step counter and synchronizer flops 0.
REQ-023 After rst_n deasserts, first state change SHALL occur no earlier than the third rising edge (synchronizer latency).

Configuration
REQ-024 Macro RGB_BREATHE_EN defined: per colour, duty ramps UP +1 per step tick 0->255, then DOWN -1 per tick 255->0; on the step tick at duty==0 in DOWN, advance colour (511 ticks per colour).
REQ-025 RGB_BREATHE_EN undefined: duty set to 255 on colour entry, held for HOLD_STEPS step ticks, then advance colour; ramp logic absent.

Verification
REQ-026 Reset: rst_n=0 with seq_enable=1 for 10 cycles -> all pwm outputs 0, seq_state 0; release -> seq_state 1 within 3 cycles.
REQ-027 PWM duty: force steady duty_shadow=64 (STEP_CYCLES large) -> each active output high exactly 64 of every 256 cycles; duty 0 -> 0 high cycles; duty 255 -> 255.
REQ-028 Glitch-free update: duty changes at pwm_cnt==100 -> new high count seen only from next period starting at pwm_cnt==0.
REQ-029 Breathing (RGB_BREATHE_EN, STEP_CYCLES=4): seq_enable=1 -> RED for 511*4 cycles, then seq_state 2; after four colours back to 1.
REQ-030 Hold mode (no macro, STEP_CYCLES=4, HOLD_STEPS=8): each colour lasts 32 cycles at 255/256 duty; WHITE drives all three identically.
REQ-031 Mid-ramp disable: drop seq_enable at duty 130 UP in GREEN -> seq_state 0 and all outputs low within 4 cycles; re-enable -> restarts at RED, duty 0.
